fraction_mult_arbiter: RTL
==========================

Name: fraction_mult_arbiter

Overview:
- Shares one fraction_multiplier4-style sequential multiplier (St/Mplier/Mcand in, Product/Done out) among NREQ requesters.
- Arbitrates round-robin and latches the winner's operands. Pulses St, waits for Done, captures Product and returns it to the owner with a one-cycle Ack.
- The multiplier has no reset. A post-reset flush window lets any in-flight operation finish before new work is issued.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 4, operand width (Mplier/Mcand)
- PW, 7, product width (2*W-1)
- FLUSH_CYC, 12, idle cycles after reset before the first grant (≥ worst-case multiplier latency)
- TIMEOUT, 15, WAIT-state cycle limit (used only with the optional feature)

Ports:
- CLK  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- Req  in  NREQ  per-requester request level
- Mplier_in  in  NREQ*W  operands; slice i = bits [i*W +: W]
- Mcand_in  in  NREQ*W  operands; same slicing
- Gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester were sampled
- Ack  out  NREQ  one-hot, one-cycle pulse: Result valid for that requester
- Result  out  PW  last captured product; held until the next capture
- Busy  out  1  high in every state except IDLE
- mul_St  out  1  start pulse to the multiplier
- mul_Mplier  out  W  latched operand
- mul_Mcand  out  W  latched operand
- mul_Product  in  PW  multiplier product
- mul_Done  in  1  multiplier done

Behaviour:
- All outputs and state are registered.
- Reset (async, any state) sets: state=FLUSH, flush counter=0, Gnt=Ack=0, mul_St=0, Result=0, Busy=1, owner=0, last=NREQ-1 (requester 0 wins first).
- FLUSH: counts FLUSH_CYC cycles. Req and mul_Done are ignored. Then → IDLE.
- IDLE: Busy=0.
  - If Req≠0, the winner is the first set bit searching upward from last+1, modulo NREQ.
  - On that edge: latch the winner's operands into mul_Mplier/mul_Mcand, set owner=winner, drive Gnt[winner]=1 and mul_St=1 for the next cycle, → START.
  - A stray mul_Done is ignored.
- START: one cycle. Gnt and mul_St high, operands stable. → WAIT. Gnt and mul_St return to 0.
- WAIT: hold operands.
  - On the first cycle with mul_Done=1: Result←mul_Product, Ack[owner]=1 next cycle, last←owner, → RESP.
  - mul_Done already high in the first WAIT cycle is accepted.
- RESP: one cycle with Ack[owner] high and Result valid. → IDLE.
- Latency: Req seen in IDLE → Gnt 1 cycle later → Ack (multiplier latency + 3) cycles after the Req sample.
- Requester rules: hold Req and operands until Gnt is seen, then drop Req. A Req still high on return to IDLE counts as a new request.
- Simultaneous requests: exactly one grant per transaction. With all requesters asserting, service order is 0,1,2,3,0,...
- A requester's Req dropping before Gnt withdraws its request and causes no error.
- Gnt and Ack are never both high. At most one bit of each is set.

Optional Feature:
- MULT_ARB_TIMEOUT_EN defined:
  - Adds output Err (1 bit, reset 0) and a WAIT cycle counter.
  - If TIMEOUT cycles pass in WAIT without mul_Done: Result←0, Ack[owner]=1 with Err=1 for that one cycle, last←owner, → FLUSH (not IDLE). The flush guards against a late Done.
  - Err=0 on normal Acks.
- Not defined: no Err port and no counter. WAIT waits indefinitely for mul_Done.

Test Plan (the bench multiplier model asserts Done 10 cycles after St and returns 7'h10 for 4'h4×4'h4):
- Single request: Req=4'b0010, operands 4'h4/4'h4 after flush → Gnt=0010 for 1 cycle, mul_St 1 cycle with 4'h4/4'h4, Ack=0010 13 cycles after the Req sample, Result=7'h10.
- Contention: Req=4'b1111 held, each requester drops after its Gnt → grants in order 0,1,2,3, one transaction at a time, Busy low only in IDLE cycles.
- Round-robin fairness: after serving 2, Req=4'b0101 → requester 0 wins (search starts at 3, wraps to 0); next grant goes to 2.
- Reset mid-WAIT: Rst_n low 1 cycle, model still busy → Ack/Gnt stay 0. No St for FLUSH_CYC cycles. The late Done is ignored. The next request completes normally.
- Flush gating: Req held high from reset → first Gnt exactly FLUSH_CYC+1 cycles after Rst_n rises.
- With MULT_ARB_TIMEOUT_EN, model never asserts Done → Ack[owner]=1 and Err=1 after TIMEOUT cycles in WAIT, Result=0, then FLUSH. A new request is granted after the flush.

Source files
------------

// File: rtl/fraction_mult_arbiter.sv
// fraction_mult_arbiter
//   Shares one sequential fraction multiplier (St/Mplier/Mcand -> Product/Done)
//   among NREQ requesters. Requesters are served round-robin. The winner's
//   operands are latched and St is pulsed. The arbiter then waits for Done,
//   captures Product and returns it to the owner with a one-cycle Ack.
//   The multiplier has no reset of its own. After every reset the arbiter
//   therefore sits in FLUSH for FLUSH_CYC cycles, so that an operation still
//   in flight can finish before new work is issued.
//
// Optional feature macro: MULT_ARB_TIMEOUT_EN
//   When defined, the arbiter adds an Err output and a WAIT-cycle counter.
//   If TIMEOUT cycles pass in WAIT without Done, the owner receives an Ack
//   with Err=1 and Result=0, and the arbiter re-enters FLUSH.
//
// Ports
//   CLK          in   clock, rising edge
//   Rst_n        in   asynchronous active-low reset
//   Req          in   [NREQ]    per-requester request level
//   Mplier_in    in   [NREQ*W]  operand i at bits [i*W +: W]
//   Mcand_in     in   [NREQ*W]  operand i at bits [i*W +: W]
//   Gnt          out  [NREQ]    one-hot pulse: that requester's operands were sampled
//   Ack          out  [NREQ]    one-hot pulse: Result is valid for that requester
//   Result       out  [PW]      last captured product, held until the next capture
//   Busy         out            high in every state except IDLE
//   mul_St       out            start pulse to the multiplier
//   mul_Mplier   out  [W]       latched operand
//   mul_Mcand    out  [W]       latched operand
//   mul_Product  in   [PW]      multiplier product
//   mul_Done     in             multiplier done
//   Err          out            (MULT_ARB_TIMEOUT_EN only) Ack caused by a timeout
//   dbg_state    out  [3]       current FSM state: 0 FLUSH, 1 IDLE, 2 START, 3 WAIT, 4 RESP
//
// Handshake: a requester holds Req and its operands until it sees its Gnt bit,
// then drops Req. If Req is dropped before Gnt, the request is withdrawn.
// Each Gnt is followed by exactly one Ack to the same requester, unless a
// reset intervenes. Gnt and Ack are never high in the same cycle.
module fraction_mult_arbiter #(
  parameter int NREQ      = 4,
  parameter int W         = 4,
  parameter int PW        = 7,
  parameter int FLUSH_CYC = 12,
  parameter int TIMEOUT   = 15
) (
  input  logic              CLK,
  input  logic              Rst_n,
  input  logic [NREQ-1:0]   Req,
  input  logic [NREQ*W-1:0] Mplier_in,
  input  logic [NREQ*W-1:0] Mcand_in,
  output logic [NREQ-1:0]   Gnt,
  output logic [NREQ-1:0]   Ack,
  output logic [PW-1:0]     Result,
  output logic              Busy,
  output logic              mul_St,
  output logic [W-1:0]      mul_Mplier,
  output logic [W-1:0]      mul_Mcand,
  input  logic [PW-1:0]     mul_Product,
  input  logic              mul_Done,
`ifdef MULT_ARB_TIMEOUT_EN
  output logic              Err,
`endif
  output logic [2:0]        dbg_state
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FCW = $clog2(FLUSH_CYC + 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  if (NREQ < 2 || NREQ > 8 || PW != 2*W-1 || FLUSH_CYC < 1 || TIMEOUT < 1) begin : g_param_check
    $error("fraction_mult_arbiter: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_FLUSH = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t           r_state;
  logic [FCW-1:0]   r_fcnt;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_ack;
  logic             r_st;
  logic [PW-1:0]    r_result;
  logic             r_busy;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_last;
  logic [W-1:0]     r_mpl;
  logic [W-1:0]     r_mcd;
`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic             r_err;
  logic [TCW-1:0]   r_wcnt;
`endif

  // Per-requester operand views so the winner can select by index.
  logic [W-1:0] w_mpl_arr [NREQ];
  logic [W-1:0] w_mcd_arr [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_mpl_arr[g] = Mplier_in[g*W +: W];
    assign w_mcd_arr[g] = Mcand_in[g*W +: W];
  end

  // Round-robin search: first set Req bit starting at last+1, wrapping.
  logic          w_found;
  logic [IW-1:0] w_winner;
  logic [IW-1:0] w_idx;
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IW'((int'(r_last) + k) % NREQ);
      if (!w_found && Req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= S_FLUSH;
      r_fcnt   <= '0;
      r_gnt    <= '0;
      r_ack    <= '0;
      r_st     <= 1'b0;
      r_result <= '0;
      r_busy   <= 1'b1;
      r_owner  <= '0;
      r_last   <= IW'(NREQ - 1);
      r_mpl    <= '0;
      r_mcd    <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      r_err    <= 1'b0;
      r_wcnt   <= '0;
`endif
    end else begin
      // Gnt, Ack, St and Err are single-cycle pulses.
      r_gnt <= '0;
      r_ack <= '0;
      r_st  <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_FLUSH: begin
          // Req and mul_Done are ignored until the multiplier is known idle.
          if (r_fcnt == FCW'(FLUSH_CYC - 1)) begin
            r_fcnt  <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_winner;
            r_mpl   <= w_mpl_arr[w_winner];
            r_mcd   <= w_mcd_arr[w_winner];
            r_gnt   <= ONE_HOT0 << w_winner;
            r_st    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
          r_wcnt  <= '0;
`endif
        end
        S_WAIT: begin
          if (mul_Done) begin
            r_result <= mul_Product;
            r_ack    <= ONE_HOT0 << r_owner;
            r_last   <= r_owner;
            r_state  <= S_RESP;
          end
`ifdef MULT_ARB_TIMEOUT_EN
          else if (r_wcnt == TCW'(TIMEOUT - 1)) begin
            // The multiplier may still raise Done late; FLUSH absorbs it.
            r_result <= '0;
            r_ack    <= ONE_HOT0 << r_owner;
            r_err    <= 1'b1;
            r_last   <= r_owner;
            r_fcnt   <= '0;
            r_state  <= S_FLUSH;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_FLUSH;
          r_fcnt  <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign Gnt        = r_gnt;
  assign Ack        = r_ack;
  assign Result     = r_result;
  assign Busy       = r_busy;
  assign mul_St     = r_st;
  assign mul_Mplier = r_mpl;
  assign mul_Mcand  = r_mcd;
  assign dbg_state  = r_state;
`ifdef MULT_ARB_TIMEOUT_EN
  assign Err        = r_err;
`endif

endmodule
